nibble_serial_borrow_lookahead_subtractor: RTL and testbench
============================================================

// Module: nibble_serial_borrow_lookahead_subtractor
// PURPOSE
//  Sequential multi-word subtractor: diff = a - b - bin over WIDTH bits.
//  Processes one 4-bit nibble per clock using a 4-bit borrow-lookahead slice.
//  The slice is the subtract-direction counterpart of the team's carry-lookahead adder.
//  Valid/ready handshake on both sides; sits in datapaths where area matters more than latency.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 4
//  N = WIDTH/4 (localparam): nibble count and cycles per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, bin are valid
//  in_ready   out  1      block can accept operands; equals (state==IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout/ovf are valid; equals (state==DONE)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  registered difference
//  bout       out  1      borrow out: 1 when a < b + bin (unsigned)
//  ovf        out  1      signed overflow (present only with SUB_OVF_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, so in_ready=1 and out_valid=0.
//   - diff=0, bout=0, ovf=0, nibble counter=0, operand regs=0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: when in_valid&&in_ready, latch a, b, bin into internal regs.
//     Also set cnt=0 and borrow=bin, then go to RUN.
//   - RUN: each cycle process nibble k=cnt, bits [4k+3:4k].
//     - g_i = ~a_i & b_i (generate), p_i = ~(a_i ^ b_i) (propagate).
//     - Borrows use full lookahead: b1 = g0|p0&b0; b2 = g1|p1&g0|p1&p0&b0; likewise b3, b4.
//     - d_i = a_i ^ b_i ^ borrow_i. Write d into diff[4k+3:4k].
//     - borrow <= b4; cnt <= cnt+1.
//     - On the last nibble (cnt==N-1): bout <= b4, go to DONE.
//   - DONE: hold all outputs. When out_ready=1, go to IDLE on the same edge.
//  Latency:
//   - Acceptance edge T: first nibble at T+1, last nibble at T+N.
//   - out_valid=1 in the cycle after edge T+N.
//   - WIDTH=4 gives out_valid one cycle after acceptance.
//  Throughput: one op per N+2 cycles with out_ready held high.
//  Handshake rules:
//   - in_valid is ignored outside IDLE; operands are sampled only at acceptance.
//   - Input changes during RUN have no effect.
//   - out_valid stays high and diff/bout/ovf stay stable until out_ready is sampled high.
//   - out_ready is ignored outside DONE.
//  Data visibility:
//   - diff is overwritten nibble by nibble during RUN.
//   - diff is meaningful only while out_valid=1.
//   - After the result is consumed, diff/bout keep their last value until the next RUN.
//  Wrap-around: result is modulo 2^WIDTH. 0 - 1 gives all ones with bout=1.
//  Reset mid-RUN or mid-DONE: the operation is aborted with no output.
//   - All state returns to the reset values immediately.
// CONFIGURATION
//  SUB_OVF_EN defined:
//   - ovf port exists.
//   - On the last nibble: ovf <= (a[W-1]^b[W-1]) & (d[W-1]^a[W-1]).
//     a and b here are the latched operands.
//   - ovf is held with diff; reset to 0.
//  SUB_OVF_EN undefined: no ovf port, no overflow logic. Everything else is identical.
// TESTING
//  1. WIDTH=16, a=0x1234, b=0x0034, bin=0, out_ready=1 -> out_valid 4 cycles after accept.
//     diff=0x1200, bout=0.
//  2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; ovf=0 if SUB_OVF_EN.
//  3. a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, bout=0; ovf=1 if SUB_OVF_EN.
//  4. Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
//     -> in_ready=0 throughout; diff/bout stable; new operands not taken.
//     -> IDLE one edge after out_ready=1.
//  5. Pulse rst_n=0 during cycle 2 of RUN.
//     -> out_valid=0, in_ready=1, diff=0 immediately.
//     -> the next op after reset (a=0x00FF, b=0x000F) gives diff=0x00F0.
//  6. 1000 random a/b/bin with random out_ready stalls.
//     -> diff/bout match {bout,diff} = {1'b0,a} - b - bin; ovf matches signed model.

Source files
------------

// File: rtl/nibble_serial_borrow_lookahead_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_borrow_lookahead_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               borrow;

  logic [CNT_W+1:0]   idx;
  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [3:0]         g;
  logic [3:0]         p;
  logic [4:0]         bc;
  logic [3:0]         d;
  logic               last;

  // bc[i] is the borrow into bit i; bc[4] is the slice borrow-out.
  function automatic logic [4:0] borrow_chain(input logic [3:0] gg, input logic [3:0] pp,
                                              input logic b0);
    logic [4:0] c;
    c[0] = b0;
    c[1] = gg[0] | (pp[0] & b0);
    c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & b0);
    c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & b0);
    c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
         | (&pp & b0);
    return c;
  endfunction

  assign idx   = {cnt, 2'b00};
  assign a_nib = a_r[idx +: 4];
  assign b_nib = b_r[idx +: 4];
  assign g     = ~a_nib & b_nib;
  assign p     = ~(a_nib ^ b_nib);
  assign bc    = borrow_chain(g, p, borrow);
  assign d     = a_nib ^ b_nib ^ bc[3:0];
  assign last  = (cnt == CNT_W'(N - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          diff[idx +: 4] <= d;
          borrow         <= bc[4];
          cnt            <= cnt + 1'b1;
          if (last) begin
            bout  <= bc[4];
`ifdef SUB_OVF_EN
            // Operands of differing sign overflow when the result sign departs from a's.
            ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d[3] ^ a_r[WIDTH-1]);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_borrow_lookahead_subtractor.sv
// Self-checking bench for nibble_serial_borrow_lookahead_subtractor (WIDTH=16).
// Honours SUB_OVF_EN the same way as the design.
module tb_nibble_serial_borrow_lookahead_subtractor;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned W+1-bit subtraction gives {bout, diff}.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  // Reference: true signed result falls outside the W-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint sx, sy, s, lim;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    s   = sx - sy - longint'(c);
    lim = longint'(1) <<< (W - 1);
    return (s < -lim) || (s > lim - 1);
  endfunction

  // Offer operands from a negedge until accepted; scramble the inputs afterwards.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int guard;
    @(negedge clk);
    a = ta; b = tb; bin = tc; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Called #1 after the acceptance edge; counts edges until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc);
    logic [W:0] r;
    r = ref_sub(ta, tb, tc);
    chk({tag, "_diff"}, 64'(diff), 64'(r[W-1:0]));
    chk({tag, "_bout"}, 64'(bout), 64'(r[W]));
`ifdef SUB_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb, tc)));
`endif
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb, hold_d;
    logic rc, hold_b;
    int stall;

    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: basic subtract and latency
    start_op(16'h1234, 16'h0034, 1'b0);
    chk("t1_run_in_ready", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("t1_latency", 64'(lat), 64'(N));
    chk("t1_diff_const", 64'(diff), 64'h1200);
    check_result("t1", 16'h1234, 16'h0034, 1'b0);
    consume();
    chk("t1_back_idle", 64'(in_ready), 64'd1);
    chk("t1_ov_low", 64'(out_valid), 64'd0);
    chk("t1_diff_kept", 64'(diff), 64'h1200);

    // Wrap-around
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(lat);
    chk("t2_diff_const", 64'(diff), 64'hFFFF);
    chk("t2_bout_const", 64'(bout), 64'd1);
    check_result("t2", 16'h0000, 16'h0001, 1'b0);
    consume();

    // Borrow-in into most-negative value
    start_op(16'h8000, 16'h0000, 1'b1);
    wait_done(lat);
    chk("t3_diff_const", 64'(diff), 64'h7FFF);
    chk("t3_bout_const", 64'(bout), 64'd0);
`ifdef SUB_OVF_EN
    chk("t3_ovf_const", 64'(ovf), 64'd1);
`endif
    check_result("t3", 16'h8000, 16'h0000, 1'b1);

    // Stall in DONE with new operands offered
    hold_d = diff; hold_b = bout;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; bin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t4_in_ready", 64'(in_ready), 64'd0);
      chk("t4_out_valid", 64'(out_valid), 64'd1);
      chk("t4_diff_hold", 64'(diff), 64'(hold_d));
      chk("t4_bout_hold", 64'(bout), 64'(hold_b));
    end
    in_valid = 1'b0;
    consume();
    chk("t4_idle", 64'(in_ready), 64'd1);
    chk("t4_diff_kept", 64'(diff), 64'(hold_d));

    // Reset mid-RUN
    start_op(16'hFFFF, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_running", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_diff", 64'(diff), 64'd0);
    chk("t5_bout", 64'(bout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h00FF, 16'h000F, 1'b0);
    wait_done(lat);
    chk("t5_latency", 64'(lat), 64'(N));
    chk("t5_diff_const", 64'(diff), 64'h00F0);
    check_result("t5", 16'h00FF, 16'h000F, 1'b0);
    consume();

    // Random operands with random consumer stalls
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (n % 50 == 0) ra = rb;
      start_op(ra, rb, rc);
      wait_done(lat);
      chk("rnd_latency", 64'(lat), 64'(N));
      check_result("rnd", ra, rb, rc);
      stall = $urandom_range(0, 3);
      hold_d = diff;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
        chk("rnd_stall_hold", 64'({out_valid, diff}), 64'({1'b1, hold_d}));
      end
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
